// File: rtl/lycan_globals_pkg.sv
// lycan_globals: shared config-packet, opcode and routing-table types for the lycan pin router
package lycan_globals;
  localparam int PKT_OPCODE_MSB = 31;
  localparam int PKT_OPCODE_LSB = 28;
  localparam int DEFAULT_DEAD_CYCLES = 4;
  typedef enum logic [3:0] {
    OP_MAP_OUT      = 4'd1,
    OP_MAP_IN       = 4'd2,
    OP_UNMAP_PIN    = 4'd3,
    OP_COMMIT       = 4'd4,
    OP_CLEAR_STAGED = 4'd5
  } lycan_cfg_op_e;
  typedef struct packed {
    logic [3:0]  opcode;
    logic [11:0] pin;
    logic [7:0]  periph;
    logic [7:0]  slot;
  } lycan_cfg_pkt_t;
  typedef struct packed {
    logic       valid;
    logic [7:0] periph;
    logic [7:0] slot;
  } pin_map_entry_t;
  typedef struct packed {
    logic        valid;
    logic [11:0] pin;
  } in_map_entry_t;
endpackage

// File: rtl/lycan_pin_router_sync.sv
// lycan_pin_sync: W-bit two-flop synchroniser, reset to 0 (ports: clk, rst, d in, q out)
module lycan_pin_sync #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/lycan_pin_router.sv
// lycan_pin_router: runtime-configurable crossbar between peripheral I/O slots and DUT pins.
// Ports: clk/rst (sync, active-high); cfg_data/cfg_valid/cfg_ready config packets; cfg_err sticky
// error; busy during commit; periph_out/periph_oe/periph_in peripheral slots; pin_out/pin_oe/pin_in pads.
// Define LYCAN_ROUTER_SYNC_EN to pass pin_in through a 2-flop synchroniser (pin_in->periph_in = 3 cycles).
module lycan_pin_router
  import lycan_globals::*;
#(
  parameter int NUM_PINS        = 16,
  parameter int NUM_PERIPHS     = 8,
  parameter int OUTS_PER_PERIPH = 4,
  parameter int INS_PER_PERIPH  = 3,
  parameter int PKT_W           = 32,
  parameter int DEAD_CYCLES     = DEFAULT_DEAD_CYCLES
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PKT_W-1:0]                       cfg_data,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  output logic                                   cfg_err,
  output logic                                   busy,
  input  logic [NUM_PERIPHS*OUTS_PER_PERIPH-1:0] periph_out,
  input  logic [NUM_PERIPHS*OUTS_PER_PERIPH-1:0] periph_oe,
  output logic [NUM_PERIPHS*INS_PER_PERIPH-1:0]  periph_in,
  output logic [NUM_PINS-1:0]                    pin_out,
  output logic [NUM_PINS-1:0]                    pin_oe,
  input  logic [NUM_PINS-1:0]                    pin_in
);
  localparam int NO  = NUM_PERIPHS * OUTS_PER_PERIPH;
  localparam int NI  = NUM_PERIPHS * INS_PER_PERIPH;
  localparam int PW  = NUM_PINS > 1 ? $clog2(NUM_PINS) : 1;
  localparam int OW  = NO > 1 ? $clog2(NO) : 1;
  localparam int IW  = NI > 1 ? $clog2(NI) : 1;
  localparam int OPW = PKT_OPCODE_MSB - PKT_OPCODE_LSB + 1;
  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_e;
  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           cfg_err_q, cfg_err_d;
  pin_map_entry_t so_q [NUM_PINS], so_d [NUM_PINS], ao_q [NUM_PINS], ao_d [NUM_PINS];
  in_map_entry_t  si_q [NI], si_d [NI], ai_q [NI], ai_d [NI];
  logic [NUM_PINS-1:0] pin_out_q, pin_out_d, pin_oe_q, pin_oe_d, pin_src;
  logic [NI-1:0]       periph_in_q, periph_in_d;
  lycan_cfg_pkt_t pkt;
  logic [OPW-1:0] op;
  logic           acc, bad, pin_ok, p_ok, so_ok, si_ok, oe_en;
  logic [IW-1:0]  ii;
  logic [OW-1:0]  oi;
  assign pkt       = lycan_cfg_pkt_t'(cfg_data);
  assign op        = pkt.opcode;
  assign cfg_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign cfg_err   = cfg_err_q;
  assign pin_out   = pin_out_q;
  assign pin_oe    = pin_oe_q;
  assign periph_in = periph_in_q;
`ifdef LYCAN_ROUTER_SYNC_EN
  lycan_pin_sync #(.W(NUM_PINS)) u_sync (.clk(clk), .rst(rst), .d(pin_in), .q(pin_src));
`else
  assign pin_src = pin_in;
`endif
  always_comb begin
    pin_ok = int'(pkt.pin) < NUM_PINS;
    p_ok   = int'(pkt.periph) < NUM_PERIPHS;
    so_ok  = int'(pkt.slot) < OUTS_PER_PERIPH;
    si_ok  = int'(pkt.slot) < INS_PER_PERIPH;
    ii     = IW'(int'(pkt.periph) * INS_PER_PERIPH + int'(pkt.slot));
    acc    = cfg_valid && state_q == IDLE;
    bad    = op == OP_MAP_OUT   ? !(pin_ok && p_ok && so_ok) :
             op == OP_MAP_IN    ? !(pin_ok && p_ok && si_ok) :
             op == OP_UNMAP_PIN ? !pin_ok :
             !(op == OP_COMMIT || op == OP_CLEAR_STAGED);
    state_d   = state_q;
    cnt_d     = cnt_q;
    cfg_err_d = cfg_err_q;
    so_d      = so_q;
    si_d      = si_q;
    ao_d      = ao_q;
    ai_d      = ai_q;
    if (state_q == DRAIN) begin
      cnt_d   = cnt_q - 8'd1;
      state_d = cnt_q == 8'd0 ? APPLY : DRAIN;
    end
    if (state_q == APPLY) begin
      ao_d    = so_q;
      ai_d    = si_q;
      state_d = IDLE;
    end
    if (acc) begin
      if (bad) cfg_err_d = 1'b1;
      else if (op == OP_COMMIT) begin
        state_d = DRAIN;
        cnt_d   = 8'(DEAD_CYCLES - 1);
      end else if (op == OP_CLEAR_STAGED) begin
        cfg_err_d = 1'b0;
        so_d      = '{default: '0};
        si_d      = '{default: '0};
      end else if (op == OP_MAP_OUT) so_d[pkt.pin[PW-1:0]] = '{1'b1, pkt.periph, pkt.slot};
      else if (op == OP_MAP_IN) si_d[ii] = '{1'b1, pkt.pin};
      else so_d[pkt.pin[PW-1:0]] = '0;
    end
  end
  // Enables stay low from the commit edge until the first output computed from the new table,
  // so no pad is driven by an old mapping once the commit has started.
  always_comb begin
    oe_en     = state_q == IDLE && state_d == IDLE;
    oi        = '0;
    pin_out_d = '0;
    pin_oe_d  = '0;
    for (int n = 0; n < NUM_PINS; n++) begin
      oi           = OW'(int'(ao_q[n].periph) * OUTS_PER_PERIPH + int'(ao_q[n].slot));
      pin_out_d[n] = ao_q[n].valid && periph_out[oi];
      pin_oe_d[n]  = ao_q[n].valid && periph_oe[oi] && oe_en;
    end
    periph_in_d = '0;
    for (int j = 0; j < NI; j++) periph_in_d[j] = ai_q[j].valid && pin_src[ai_q[j].pin[PW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cfg_err_q   <= 1'b0;
      so_q        <= '{default: '0};
      ao_q        <= '{default: '0};
      si_q        <= '{default: '0};
      ai_q        <= '{default: '0};
      pin_out_q   <= '0;
      pin_oe_q    <= '0;
      periph_in_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_err_q   <= cfg_err_d;
      so_q        <= so_d;
      ao_q        <= ao_d;
      si_q        <= si_d;
      ai_q        <= ai_d;
      pin_out_q   <= pin_out_d;
      pin_oe_q    <= pin_oe_d;
      periph_in_q <= periph_in_d;
    end
  end
endmodule
